// File: rtl/custom_types.sv
// Shared types for the 4-bit CPU: opcode and register enums and the 8-bit
// instruction layout with its overlapping operand views.
package custom_types;

  localparam int unsigned DMEM_DEPTH = 16;

  typedef enum logic [3:0] {
    OPCODE_NOP  = 4'h0,
    OPCODE_MOVI = 4'h1,
    OPCODE_ADD  = 4'h2,
    OPCODE_ADDI = 4'h3,
    OPCODE_SUB  = 4'h4,
    OPCODE_SUBI = 4'h5,
    OPCODE_AND  = 4'h6,
    OPCODE_OR   = 4'h7,
    OPCODE_XOR  = 4'h8,
    OPCODE_LSLI = 4'h9,
    OPCODE_LSRI = 4'hA,
    OPCODE_LD   = 4'hB,
    OPCODE_ST   = 4'hC,
    OPCODE_BEQ  = 4'hD,
    OPCODE_BNE  = 4'hE,
    OPCODE_JMP  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    R2 = 2'd2,
    R3 = 2'd3
  } reg_t;

  typedef struct packed {
    reg_t dst;
    reg_t src;
  } regs_t;

  typedef struct packed {
    reg_t       dst;
    logic [1:0] val;
  } imm2_t;

  typedef union packed {
    regs_t      regs;
    imm2_t      imm2;
    logic [3:0] imm4;
  } operand_t;

  typedef struct packed {
    opcode_t  opcode;
    operand_t operand;
  } instruction_t;

endpackage

// File: rtl/memory.sv
// 16-entry memory: synchronous write, combinational read, async clear.
module memory
  import custom_types::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DMEM_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DMEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/mux_2to1.sv
// Two-input bus mux; lets the programmer or the CPU address instruction memory.
module mux_2to1 #(
  parameter int unsigned BUS_WIDTH = 1
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 sel,
  output logic [BUS_WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/cpu4_core.sv
// Single-cycle 4-bit Harvard CPU with internal 16x4 data memory.
// Define CPU_TRACE_EN to print per-cycle architectural state in simulation.
module cpu4_core
  import custom_types::*;
(
  input  logic         clk,
  input  logic         reset,
  input  instruction_t instr_data,
  output logic [3:0]   instr_addr
);

  logic [3:0] r_pc;
  logic [3:0] r_regs [4];
  logic       r_z;

  opcode_t    w_op;
  logic [1:0] w_dst;
  logic [1:0] w_src;
  logic [3:0] w_val;
  logic [3:0] w_imm4;
  logic [3:0] w_rd;
  logic [3:0] w_rs;
  logic [3:0] w_result;
  logic [3:0] w_dmem_rdata;
  logic [3:0] w_pc_next;
  logic       w_reg_we;
  logic       w_dmem_we;

  assign w_op   = instr_data.opcode;
  assign w_dst  = instr_data.operand.regs.dst;
  assign w_src  = instr_data.operand.regs.src;
  assign w_val  = {2'b00, instr_data.operand.imm2.val};
  assign w_imm4 = instr_data.operand.imm4;
  assign w_rd   = r_regs[w_dst];
  assign w_rs   = r_regs[w_src];

  // Every register-writing opcode also updates Z from the written value.
  always_comb begin
    w_result  = '0;
    w_reg_we  = 1'b0;
    w_dmem_we = 1'b0;
    w_pc_next = r_pc + 4'd1;
    case (w_op)
      OPCODE_NOP:  ;
      OPCODE_MOVI: begin w_result = w_val;                 w_reg_we = 1'b1; end
      OPCODE_ADD:  begin w_result = w_rd + w_rs;           w_reg_we = 1'b1; end
      OPCODE_ADDI: begin w_result = w_rd + w_val;          w_reg_we = 1'b1; end
      OPCODE_SUB:  begin w_result = w_rd - w_rs;           w_reg_we = 1'b1; end
      OPCODE_SUBI: begin w_result = w_rd - w_val;          w_reg_we = 1'b1; end
      OPCODE_AND:  begin w_result = w_rd & w_rs;           w_reg_we = 1'b1; end
      OPCODE_OR:   begin w_result = w_rd | w_rs;           w_reg_we = 1'b1; end
      OPCODE_XOR:  begin w_result = w_rd ^ w_rs;           w_reg_we = 1'b1; end
      OPCODE_LSLI: begin w_result = w_rd << w_val[1:0];    w_reg_we = 1'b1; end
      OPCODE_LSRI: begin w_result = w_rd >> w_val[1:0];    w_reg_we = 1'b1; end
      OPCODE_LD:   begin w_result = w_dmem_rdata;          w_reg_we = 1'b1; end
      OPCODE_ST:   w_dmem_we = 1'b1;
      OPCODE_BEQ:  if (r_z)  w_pc_next = w_imm4;
      OPCODE_BNE:  if (!r_z) w_pc_next = w_imm4;
      OPCODE_JMP:  w_pc_next = w_imm4;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
      r_z  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_reg_we) begin
        r_regs[w_dst] <= w_result;
        r_z           <= (w_result == '0);
      end
    end
  end

  memory #(
    .WIDTH(4)
  ) u_dmem (
    .clk  (clk),
    .reset(reset),
    .we   (w_dmem_we),
    .addr (w_rs),
    .wdata(w_rd),
    .rdata(w_dmem_rdata)
  );

  assign instr_addr = r_pc;

`ifdef CPU_TRACE_EN
  always @(posedge clk) begin
    if (!reset)
      $display("%0t pc=%0d op=%s r0=%0d r1=%0d r2=%0d r3=%0d z=%0d", $time, r_pc,
               w_op.name(), r_regs[0], r_regs[1], r_regs[2], r_regs[3], r_z);
  end
`endif

endmodule

// File: tb/tb_cpu4_core.sv
// Bench for cpu4_core: instruction memory loaded through a mux, an ISA-level
// model stepped each cycle, plus hand-computed checks on directed programs.
module tb_cpu4_core;

  logic       clk;
  logic       rst;
  logic       imem_rst;
  logic       prog_mode;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_wdata;
  logic [3:0] cpu_addr;
  logic [3:0] imem_addr;
  logic [7:0] imem_rdata;

  int total = 0;
  int bad   = 0;

  // ISA-level reference state
  int         m_pc;
  int         m_r    [4];
  int         m_z;
  int         m_dmem [16];
  logic [7:0] m_imem [16];
  logic [7:0] prog   [16];
  bit         chk_en = 0;

  mux_2to1 #(.BUS_WIDTH(4)) u_mux (
    .a  (cpu_addr),
    .b  (prog_addr),
    .sel(prog_mode),
    .y  (imem_addr)
  );

  memory #(.WIDTH(8)) u_imem (
    .clk  (clk),
    .reset(imem_rst),
    .we   (prog_we),
    .addr (imem_addr),
    .wdata(prog_wdata),
    .rdata(imem_rdata)
  );

  cpu4_core dut (
    .clk       (clk),
    .reset     (rst),
    .instr_data(imem_rdata),
    .instr_addr(cpu_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] enc(input int op, input int d, input int s);
    return 8'(op * 16 + d * 4 + s);
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_z  = 0;
    for (int i = 0; i < 4; i++)  m_r[i] = 0;
    for (int i = 0; i < 16; i++) m_dmem[i] = 0;
  endtask

  task automatic model_step();
    int ins, op, k, d, s, a, b, res;
    bit wr, taken;
    ins   = int'(m_imem[m_pc]);
    op    = ins / 16;
    k     = ins % 16;
    d     = k / 4;
    s     = k % 4;
    a     = m_r[d];
    b     = m_r[s];
    res   = 0;
    wr    = 1;
    taken = 0;
    case (op)
      1:  res = s;
      2:  res = a + b;
      3:  res = a + s;
      4:  res = a - b;
      5:  res = a - s;
      6:  res = a & b;
      7:  res = a | b;
      8:  res = a ^ b;
      9:  res = a * (1 << s);
      10: res = a / (1 << s);
      11: res = m_dmem[b];
      default: wr = 0;
    endcase
    if (op == 12) m_dmem[b] = a;
    if (op == 13 && m_z == 1) taken = 1;
    if (op == 14 && m_z == 0) taken = 1;
    if (op == 15) taken = 1;
    if (wr) begin
      res    = ((res % 16) + 16) % 16;
      m_r[d] = res;
      m_z    = (res == 0) ? 1 : 0;
    end
    m_pc = taken ? k : (m_pc + 1) % 16;
  endtask

  always @(posedge clk) begin
    if (!rst && chk_en) model_step();
  end

  // Per-cycle comparison of all architectural state against the model
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("pc", int'(dut.r_pc), m_pc);
      chk("z", int'(dut.r_z), m_z);
      for (int i = 0; i < 4; i++) chk($sformatf("r%0d", i), int'(dut.r_regs[i]), m_r[i]);
      for (int i = 0; i < 16; i++) chk($sformatf("dmem%0d", i), int'(dut.u_dmem.r_mem[i]), m_dmem[i]);
      if (!prog_mode) chk("imem_addr", int'(imem_addr), m_pc);
    end
  end

  task automatic load_prog();
    rst = 1'b1;
    model_reset();
    prog_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_addr  = 4'(i);
      prog_wdata = prog[i];
      prog_we    = 1'b1;
      m_imem[i]  = prog[i];
    end
    @(negedge clk);
    prog_we   = 1'b0;
    prog_mode = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic boot_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = enc(1, 3, 3);   // MOVI R3,3
    prog[1] = enc(1, 2, 3);   // MOVI R2,3
    prog[2] = enc(9, 3, 2);   // LSLI R3,2
    prog[3] = enc(2, 3, 2);   // ADD  R3,R2
    prog[4] = enc(1, 0, 0);   // MOVI R0,0
    prog[5] = enc(12, 3, 0);  // ST   dmem[R0]=R3
    prog[6] = enc(5, 3, 1);   // SUBI R3,1
    prog[7] = enc(3, 0, 1);   // ADDI R0,1
    prog[8] = enc(14, 1, 1);  // BNE  5
    prog[9] = enc(13, 2, 1);  // BEQ  9
  endtask

  initial begin
    rst        = 1'b1;
    imem_rst   = 1'b1;
    prog_mode  = 1'b1;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    model_reset();
    #12;
    imem_rst = 1'b0;

    // Reset state
    chk("rst_pc", int'(cpu_addr), 0);
    chk("rst_z", int'(dut.r_z), 0);
    for (int i = 0; i < 4; i++) chk("rst_reg", int'(dut.r_regs[i]), 0);

    // Memory and mux
    @(negedge clk);
    prog_addr  = 4'd3;
    prog_wdata = 8'hA5;
    prog_we    = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    #1;
    chk("mux_sel1", int'(imem_addr), 3);
    chk("imem_rd", int'(imem_rdata), 'hA5);
    prog_mode = 1'b0;
    #1;
    chk("mux_sel0", int'(imem_addr), 0);
    prog_mode = 1'b1;
    imem_rst  = 1'b1;
    #1;
    chk("imem_clr", int'(imem_rdata), 0);
    imem_rst = 1'b0;

    chk_en = 1;

    // Boot program
    boot_prog();
    load_prog();
    run(80);
    chk("boot_pc", int'(dut.r_pc), 9);
    chk("boot_r0", int'(dut.r_regs[0]), 0);
    chk("boot_r3", int'(dut.r_regs[3]), 15);
    chk("boot_z", int'(dut.r_z), 1);
    for (int i = 0; i < 16; i++) chk("boot_dmem", int'(dut.u_dmem.r_mem[i]), 15 - i);

    // Reset mid-run, asynchronously between edges
    load_prog();
    run(30);
    chk("mid_dmem0", int'(dut.u_dmem.r_mem[0]), 15);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_pc", int'(cpu_addr), 0);
    chk("mid_z", int'(dut.r_z), 0);
    for (int i = 0; i < 4; i++) chk("mid_reg", int'(dut.r_regs[i]), 0);
    for (int i = 0; i < 16; i++) chk("mid_dmem", int'(dut.u_dmem.r_mem[i]), 0);
    @(negedge clk);
    rst = 1'b0;
    run(20);

    // Arithmetic wrap and branches
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0]  = enc(1, 1, 3);
    for (int i = 1; i <= 4; i++) prog[i] = enc(3, 1, 3);
    prog[5]  = enc(3, 1, 1);
    prog[6]  = enc(5, 1, 1);
    prog[7]  = enc(13, 3, 3);  // BEQ 15
    prog[8]  = enc(14, 2, 2);  // BNE 10
    prog[9]  = enc(15, 2, 1);  // JMP 9
    prog[10] = enc(1, 2, 0);
    prog[11] = enc(14, 2, 3);  // BNE 11
    prog[12] = enc(10, 1, 3);
    prog[13] = enc(8, 1, 1);
    prog[15] = enc(15, 0, 0);  // JMP 0
    load_prog();
    run(6);
    chk("wrap_r1_0", int'(dut.r_regs[1]), 0);
    chk("wrap_z1", int'(dut.r_z), 1);
    run(1);
    chk("wrap_r1_15", int'(dut.r_regs[1]), 15);
    chk("wrap_z0", int'(dut.r_z), 0);
    run(1);
    chk("beq_fall", int'(dut.r_pc), 8);
    run(1);
    chk("bne_take", int'(dut.r_pc), 10);
    run(5);
    chk("pre_jmp", int'(dut.r_pc), 15);
    run(1);
    chk("jmp0", int'(dut.r_pc), 0);

    // Load/store and natural PC wrap
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = enc(1, 0, 2);
    prog[1] = enc(1, 1, 1);
    prog[2] = enc(12, 1, 0);
    prog[3] = enc(11, 2, 0);
    prog[4] = enc(11, 3, 1);
    load_prog();
    run(4);
    chk("ld_r2", int'(dut.r_regs[2]), 1);
    chk("ld_z0", int'(dut.r_z), 0);
    chk("st_dmem2", int'(dut.u_dmem.r_mem[2]), 1);
    run(1);
    chk("ld_r3", int'(dut.r_regs[3]), 0);
    chk("ld_z1", int'(dut.r_z), 1);
    run(11);
    chk("pc_wrap", int'(dut.r_pc), 0);

    // Random programs
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      load_prog();
      run(60);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
